// File: rtl/mode_counter.sv
// mode_counter: N-bit counter with programmable terminal value, up/down/bounce/hold modes,
// enable, synchronous load with clamp and a clock-enable prescaler.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   en_i        count enable, gates both prescaler and counter
//   mode_i      00 up, 01 down, 10 bounce, 11 hold
//   load_i      synchronous load strobe (honoured even with en_i low)
//   load_val_i  value written on load, clamped to limit_i
//   limit_i     terminal value, count range is 0..limit_i inclusive
//   presc_i     counter advances once per presc_i+1 enabled cycles
//   count_o     current count
//   count_d_o   count delayed by one clock
//   dir_o       current direction, 0 = up, 1 = down
//   tc_o        one-cycle pulse aligned with the post-wrap / post-turn count value
module mode_counter #(
  parameter int unsigned N  = 8,
  parameter int unsigned PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [1:0]    mode_i,
  input  logic          load_i,
  input  logic [N-1:0]  load_val_i,
  input  logic [N-1:0]  limit_i,
  input  logic [PW-1:0] presc_i,
  output logic [N-1:0]  count_o,
  output logic [N-1:0]  count_d_o,
  output logic          dir_o,
  output logic          tc_o
);

  typedef enum logic [1:0] {
    ModeUp     = 2'b00,
    ModeDown   = 2'b01,
    ModeBounce = 2'b10,
    ModeHold   = 2'b11
  } mode_e;

  mode_e         mode;
  logic [PW-1:0] pre_q, pre_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic [N-1:0]  cnt_dly_q;
  logic          dir_q, dir_d;
  logic          tc_q, tc_d;
  logic          active;
  logic          tick;

  assign mode = mode_e'(mode_i);

  // Hold mode freezes the prescaler as well as the count.
  assign active = en_i && (mode != ModeHold);
  assign tick   = active && (pre_q == presc_i);

  always_comb begin
    pre_d = pre_q;
    if (load_i) begin
      pre_d = '0;
    end else if (active) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    tc_d  = 1'b0;
    if (load_i) begin
      cnt_d = (load_val_i > limit_i) ? limit_i : load_val_i;
    end else if (tick) begin
      if (cnt_q > limit_i) begin
        // Limit was lowered below the current count: restart from zero in any mode.
        cnt_d = '0;
        dir_d = 1'b0;
        tc_d  = 1'b1;
      end else begin
        case (mode)
          ModeUp: begin
            dir_d = 1'b0;
            if (cnt_q == limit_i) begin
              cnt_d = '0;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + N'(1);
            end
          end
          ModeDown: begin
            dir_d = 1'b1;
            if (cnt_q == '0) begin
              cnt_d = limit_i;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - N'(1);
            end
          end
          ModeBounce: begin
            if (limit_i == '0) begin
              // Degenerate range: no room to turn, so pin at zero and pulse every tick.
              cnt_d = '0;
              dir_d = 1'b0;
              tc_d  = 1'b1;
            end else if (!dir_q) begin
              if (cnt_q == limit_i) begin
                cnt_d = limit_i - N'(1);
                dir_d = 1'b1;
                tc_d  = 1'b1;
              end else begin
                cnt_d = cnt_q + N'(1);
              end
            end else begin
              if (cnt_q == '0) begin
                cnt_d = N'(1);
                dir_d = 1'b0;
                tc_d  = 1'b1;
              end else begin
                cnt_d = cnt_q - N'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      cnt_dly_q <= '0;
      dir_q     <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      cnt_dly_q <= cnt_q;
      dir_q     <= dir_d;
      tc_q      <= tc_d;
    end
  end

  assign count_o   = cnt_q;
  assign count_d_o = cnt_dly_q;
  assign dir_o     = dir_q;
  assign tc_o      = tc_q;

endmodule

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter (N=4): a vector table for reset, down, bounce, load/clamp,
// runtime limit change, hold and reset-mid-bounce, plus hand sequences for the full up wrap
// and the prescaler with enable gaps and a prescaler-clearing load.
module tb_mode_counter;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic          load;
  logic [N-1:0]  load_val;
  logic [N-1:0]  limit;
  logic [PW-1:0] presc;
  logic [N-1:0]  count;
  logic [N-1:0]  count_d;
  logic          dir;
  logic          tc;

  mode_counter #(.N(N), .PW(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .mode_i     (mode),
    .load_i     (load),
    .load_val_i (load_val),
    .limit_i    (limit),
    .presc_i    (presc),
    .count_o    (count),
    .count_d_o  (count_d),
    .dir_o      (dir),
    .tc_o       (tc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] prev_cnt = '0;

  typedef struct {
    logic         r;
    logic         e;
    logic [1:0]   m;
    logic         l;
    logic [N-1:0] lv;
    logic [N-1:0] lim;
    logic [N-1:0] cnt;
    logic         d;
    logic         t;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic e, logic [1:0] m, logic l, logic [N-1:0] lv,
                             logic [N-1:0] lim, logic [N-1:0] cnt, logic d, logic t);
    vec_t x;
    x.r = r; x.e = e; x.m = m; x.l = l; x.lv = lv; x.lim = lim;
    x.cnt = cnt; x.d = d; x.t = t;
    return x;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // One clock with inputs already driven; sample 1 time unit after the edge.
  task automatic cycle(input logic [N-1:0] ec, input logic ed, input logic et,
                       input string tag);
    logic [N-1:0] ecd;
    ecd = rst ? '0 : prev_cnt;
    @(posedge clk);
    #1;
    check({tag, ".count"},   8'(count),   8'(ec));
    check({tag, ".count_d"}, 8'(count_d), 8'(ecd));
    check({tag, ".dir"},     8'(dir),     8'(ed));
    check({tag, ".tc"},      8'(tc),      8'(et));
    prev_cnt = ec;
  endtask

  // Up-mode reference for the prescaler sequence.
  logic [N-1:0]  m_cnt;
  logic [PW-1:0] m_pre;

  task automatic pstep(input logic e, input logic ld, input logic [N-1:0] lv);
    logic et;
    et = 1'b0;
    en = e; load = ld; load_val = lv; mode = 2'b00; rst = 1'b0;
    if (ld) begin
      m_cnt = (lv > limit) ? limit : lv;
      m_pre = '0;
    end else if (e) begin
      if (m_pre == presc) begin
        m_pre = '0;
        if (m_cnt == limit) begin
          m_cnt = '0;
          et    = 1'b1;
        end else begin
          m_cnt = m_cnt + 1'b1;
        end
      end else begin
        m_pre = m_pre + 1'b1;
      end
    end
    cycle(m_cnt, 1'b0, et, "presc");
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b00; load = 1'b0;
    load_val = '0; limit = 4'd15; presc = '0;

    //                 r  e  m      l  lv     lim    cnt    d  t
    for (int i = 0; i < 5; i++) tbl.push_back(v(1, 1, 2'b00, 0, 4'd0, 4'd15, 4'd0, 0, 0));
    // Down from 0, limit 3
    tbl.push_back(v(0, 1, 2'b01, 0, 4'd0,  4'd3,  4'd3,  1, 1));
    tbl.push_back(v(0, 1, 2'b01, 0, 4'd0,  4'd3,  4'd2,  1, 0));
    tbl.push_back(v(0, 1, 2'b01, 0, 4'd0,  4'd3,  4'd1,  1, 0));
    tbl.push_back(v(0, 1, 2'b01, 0, 4'd0,  4'd3,  4'd0,  1, 0));
    tbl.push_back(v(0, 1, 2'b01, 0, 4'd0,  4'd3,  4'd3,  1, 1));
    // Reset, then bounce from 0 with dir=0; tc marks the turns
    tbl.push_back(v(1, 1, 2'b10, 0, 4'd0,  4'd3,  4'd0,  0, 0));
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd3,  4'd1,  0, 0));
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd3,  4'd2,  0, 0));
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd3,  4'd3,  0, 0));
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd3,  4'd2,  1, 1));
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd3,  4'd1,  1, 0));
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd3,  4'd0,  1, 0));
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd3,  4'd1,  0, 1));
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd3,  4'd2,  0, 0));
    // Load beats a same-edge tick, clamp, load with en=0, hold with en=0
    tbl.push_back(v(0, 1, 2'b00, 1, 4'd6,  4'd9,  4'd6,  0, 0));
    tbl.push_back(v(0, 1, 2'b00, 1, 4'd12, 4'd9,  4'd9,  0, 0));
    tbl.push_back(v(0, 0, 2'b00, 1, 4'd4,  4'd9,  4'd4,  0, 0));
    tbl.push_back(v(0, 0, 2'b00, 0, 4'd0,  4'd9,  4'd4,  0, 0));
    tbl.push_back(v(0, 1, 2'b00, 0, 4'd0,  4'd9,  4'd5,  0, 0));
    // Count 12, then limit lowered to 5 while in down mode
    tbl.push_back(v(0, 1, 2'b00, 1, 4'd12, 4'd15, 4'd12, 0, 0));
    tbl.push_back(v(0, 1, 2'b01, 0, 4'd0,  4'd5,  4'd0,  0, 1));
    // Hold freezes count and dir
    tbl.push_back(v(0, 1, 2'b11, 0, 4'd0,  4'd5,  4'd0,  0, 0));
    tbl.push_back(v(0, 1, 2'b01, 0, 4'd0,  4'd5,  4'd5,  1, 1));
    tbl.push_back(v(0, 1, 2'b11, 0, 4'd0,  4'd5,  4'd5,  1, 0));
    tbl.push_back(v(0, 1, 2'b11, 0, 4'd0,  4'd5,  4'd5,  1, 0));
    // Bounce with limit 0: first out-of-range, then pinned at 0 with tc every tick
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd0,  4'd0,  0, 1));
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd0,  4'd0,  0, 1));
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd0,  4'd0,  0, 1));
    // Reset mid-bounce while dir=1
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd3,  4'd1,  0, 0));
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd3,  4'd2,  0, 0));
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd3,  4'd3,  0, 0));
    tbl.push_back(v(0, 1, 2'b10, 0, 4'd0,  4'd3,  4'd2,  1, 1));
    tbl.push_back(v(1, 1, 2'b10, 0, 4'd0,  4'd3,  4'd0,  0, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].r; en = tbl[i].e; mode = tbl[i].m; load = tbl[i].l;
      load_val = tbl[i].lv; limit = tbl[i].lim; presc = '0;
      cycle(tbl[i].cnt, tbl[i].d, tbl[i].t, $sformatf("vec%0d", i));
    end

    // Full up run at limit = all-ones: 1..15 then wrap to 0 with tc.
    rst = 1'b0; en = 1'b1; mode = 2'b00; load = 1'b0; limit = 4'd15; presc = '0;
    for (int i = 1; i <= 16; i++) begin
      cycle(4'(i), 1'b0, (i == 16), $sformatf("up%0d", i));
    end

    // Prescaler: presc=2, limit=5; en gap mid-run, then a load that restarts the prescaler.
    rst = 1'b1; limit = 4'd5; presc = 4'd2;
    cycle('0, 1'b0, 1'b0, "presc_rst");
    m_cnt = '0; m_pre = '0;
    for (int i = 0; i < 20; i++) pstep(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++)  pstep(1'b0, 1'b0, '0);
    for (int i = 0; i < 7; i++)  pstep(1'b1, 1'b0, '0);
    pstep(1'b1, 1'b1, 4'd2);
    for (int i = 0; i < 20; i++) pstep(1'b1, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
